// File: rtl/regfile_dual_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dual_pkg
// Description : Shared constants and types for the dual-commit register file.
//               Provides the write/read/reset enable levels, the read-port
//               count and the read-source selector used by each read port.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_dual_pkg;

  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;
  localparam logic RST_ENABLE   = 1'b1;

  // Two read ports per issue slot, two issue slots.
  localparam int NUM_RD_PORTS = 4;

  // Where a read port takes its data from, in descending priority.
  typedef enum logic [1:0] {
    SRC_ZERO  = 2'd0,
    SRC_WR2   = 2'd1,
    SRC_WR1   = 2'd2,
    SRC_ARRAY = 2'd3
  } rd_src_e;

endpackage : regfile_dual_pkg
`default_nettype wire

// File: rtl/regfile_dual_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rd_port
// Description : One combinational read port of the register file, including
//               the commit-to-decode bypass. Slot 2 is the younger commit, so
//               its data wins over slot 1 when both target the read address.
// Ports       : rst            - synchronous reset (forces read data to 0)
//               re, raddr      - read enable and address
//               we1/waddr1/wdata1, we2/waddr2/wdata2 - this cycle's commits
//               arr_data       - array contents at raddr
//               rdata          - read data
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rd_port
  import regfile_dual_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          rst,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  logic [DW-1:0] wdata1,
  input  logic          we2,
  input  logic [AW-1:0] waddr2,
  input  logic [DW-1:0] wdata2,
  input  logic [DW-1:0] arr_data,
  output logic [DW-1:0] rdata
);

  rd_src_e w_src;

  // r0 is caught by the first test, so a commit addressed to r0 can never be
  // bypassed onto a reader.
  always_comb begin
    w_src = SRC_ARRAY;
    if (rst == RST_ENABLE || re != READ_ENABLE || raddr == '0) begin
      w_src = SRC_ZERO;
    end else if (we2 == WRITE_ENABLE && waddr2 == raddr) begin
      w_src = SRC_WR2;
    end else if (we1 == WRITE_ENABLE && waddr1 == raddr) begin
      w_src = SRC_WR1;
    end
  end

  always_comb begin
    rdata = '0;
    case (w_src)
      SRC_WR2:   rdata = wdata2;
      SRC_WR1:   rdata = wdata1;
      SRC_ARRAY: rdata = arr_data;
      default:   rdata = '0;
    endcase
  end

endmodule : regfile_rd_port
`default_nettype wire

// File: rtl/regfile_dual.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dual
// Description : Architectural GPR file plus HI/LO pair, fed by two commit
//               slots (slot 1 older, slot 2 younger) and read by four
//               combinational ports with same-cycle commit bypass.
// Ports       : clk, rst                    - clock, sync active-high reset
//               we1_i/waddr1_i/wdata1_i     - slot-1 commit
//               we2_i/waddr2_i/wdata2_i     - slot-2 commit
//               whilo_i/hi_i/lo_i           - HI/LO commit
//               re1_i..re4_i, raddr1_i..4_i - read enables / addresses
//               rdata1_o..rdata4_o          - read data (combinational)
//               hi_o, lo_o                  - bypassed HI/LO
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dual
  import regfile_dual_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we1_i,
  input  logic [AW-1:0] waddr1_i,
  input  logic [DW-1:0] wdata1_i,
  input  logic          we2_i,
  input  logic [AW-1:0] waddr2_i,
  input  logic [DW-1:0] wdata2_i,
  input  logic          whilo_i,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  input  logic          re1_i,
  input  logic          re2_i,
  input  logic          re3_i,
  input  logic          re4_i,
  input  logic [AW-1:0] raddr1_i,
  input  logic [AW-1:0] raddr2_i,
  input  logic [AW-1:0] raddr3_i,
  input  logic [AW-1:0] raddr4_i,
  output logic [DW-1:0] rdata1_o,
  output logic [DW-1:0] rdata2_o,
  output logic [DW-1:0] rdata3_o,
  output logic [DW-1:0] rdata4_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  localparam int NREGS = 2 ** AW;

  logic [DW-1:0] r_regs [NREGS];
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;

  logic [NUM_RD_PORTS-1:0] w_re;
  logic [AW-1:0]           w_raddr [NUM_RD_PORTS];
  logic [DW-1:0]           w_rdata [NUM_RD_PORTS];

  // GPR array. Slot 2 is assigned last so a same-address collision keeps
  // the younger value. r0 is never written, so it stays at its reset zero.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (we1_i == WRITE_ENABLE && waddr1_i != '0) begin
        r_regs[waddr1_i] <= wdata1_i;
      end
      if (we2_i == WRITE_ENABLE && waddr2_i != '0) begin
        r_regs[waddr2_i] <= wdata2_i;
      end
    end
  end

  // HI and LO share one enable; they always move as a pair.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (whilo_i == WRITE_ENABLE) begin
      r_hi <= hi_i;
      r_lo <= lo_i;
    end
  end

  always_comb begin
    hi_o = r_hi;
    lo_o = r_lo;
    if (rst == RST_ENABLE) begin
      hi_o = '0;
      lo_o = '0;
    end else if (whilo_i == WRITE_ENABLE) begin
      hi_o = hi_i;
      lo_o = lo_i;
    end
  end

  assign w_re       = {re4_i, re3_i, re2_i, re1_i};
  assign w_raddr[0] = raddr1_i;
  assign w_raddr[1] = raddr2_i;
  assign w_raddr[2] = raddr3_i;
  assign w_raddr[3] = raddr4_i;

  generate
    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd_port
      regfile_rd_port #(
        .DW (DW),
        .AW (AW)
      ) u_rd_port (
        .rst      (rst),
        .re       (w_re[k]),
        .raddr    (w_raddr[k]),
        .we1      (we1_i),
        .waddr1   (waddr1_i),
        .wdata1   (wdata1_i),
        .we2      (we2_i),
        .waddr2   (waddr2_i),
        .wdata2   (wdata2_i),
        .arr_data (r_regs[w_raddr[k]]),
        .rdata    (w_rdata[k])
      );
    end
  endgenerate

  assign rdata1_o = w_rdata[0];
  assign rdata2_o = w_rdata[1];
  assign rdata3_o = w_rdata[2];
  assign rdata4_o = w_rdata[3];

endmodule : regfile_dual
`default_nettype wire

// File: tb/tb_regfile_dual.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dual
// Description : Self-checking bench for regfile_dual: a table of directed
//               cycles with hand-derived expectations, then randomized cycles
//               checked against an array model of the architectural state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dual;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          we1_i, we2_i, whilo_i;
  logic [AW-1:0] waddr1_i, waddr2_i;
  logic [DW-1:0] wdata1_i, wdata2_i, hi_i, lo_i;
  logic          re1_i, re2_i, re3_i, re4_i;
  logic [AW-1:0] raddr1_i, raddr2_i, raddr3_i, raddr4_i;
  logic [DW-1:0] rdata1_o, rdata2_o, rdata3_o, rdata4_o, hi_o, lo_o;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_dual #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .we1_i    (we1_i),
    .waddr1_i (waddr1_i),
    .wdata1_i (wdata1_i),
    .we2_i    (we2_i),
    .waddr2_i (waddr2_i),
    .wdata2_i (wdata2_i),
    .whilo_i  (whilo_i),
    .hi_i     (hi_i),
    .lo_i     (lo_i),
    .re1_i    (re1_i),
    .re2_i    (re2_i),
    .re3_i    (re3_i),
    .re4_i    (re4_i),
    .raddr1_i (raddr1_i),
    .raddr2_i (raddr2_i),
    .raddr3_i (raddr3_i),
    .raddr4_i (raddr4_i),
    .rdata1_o (rdata1_o),
    .rdata2_o (rdata2_o),
    .rdata3_o (rdata3_o),
    .rdata4_o (rdata4_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d fails=%0d", n_checks, n_fail);
    $fatal(1);
  end

  typedef struct {
    logic          rst;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          we2;
    logic [AW-1:0] wa2;
    logic [DW-1:0] wd2;
    logic          whilo;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic [3:0]    re;   // bit 0 = port 1
    logic [AW-1:0] ra1, ra2, ra3, ra4;
    logic [DW-1:0] e1, e2, e3, e4;
    logic [DW-1:0] ehi, elo;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic rst_v,
    input logic we1, input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
    input logic we2, input logic [AW-1:0] wa2, input logic [DW-1:0] wd2,
    input logic whilo, input logic [DW-1:0] hi, input logic [DW-1:0] lo,
    input logic [3:0] re,
    input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
    input logic [AW-1:0] ra3, input logic [AW-1:0] ra4,
    input logic [DW-1:0] e1, input logic [DW-1:0] e2,
    input logic [DW-1:0] e3, input logic [DW-1:0] e4,
    input logic [DW-1:0] ehi, input logic [DW-1:0] elo);
    vec_t v;
    v.rst = rst_v; v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.we2 = we2; v.wa2 = wa2; v.wd2 = wd2;
    v.whilo = whilo; v.hi = hi; v.lo = lo; v.re = re;
    v.ra1 = ra1; v.ra2 = ra2; v.ra3 = ra3; v.ra4 = ra4;
    v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e4 = e4;
    v.ehi = ehi; v.elo = elo;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                       input logic wh, input logic [DW-1:0] h, input logic [DW-1:0] l,
                       input logic [3:0] re, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic [AW-1:0] r3, input logic [AW-1:0] r4);
    rst = r; we1_i = w1; waddr1_i = a1; wdata1_i = d1;
    we2_i = w2; waddr2_i = a2; wdata2_i = d2;
    whilo_i = wh; hi_i = h; lo_i = l;
    re1_i = re[0]; re2_i = re[1]; re3_i = re[2]; re4_i = re[3];
    raddr1_i = r1; raddr2_i = r2; raddr3_i = r3; raddr4_i = r4;
  endtask

  // Architectural model: register contents and HI/LO as they stand before
  // the current cycle's commit.
  logic [DW-1:0] m_regs [2**AW];
  logic [DW-1:0] m_hi, m_lo;

  initial begin
    logic [DW-1:0] nxt [2**AW];
    logic [DW-1:0] nhi, nlo;
    logic          r, w1, w2, wh;
    logic [AW-1:0] a1, a2;
    logic [AW-1:0] ra [4];
    logic [DW-1:0] d1, d2, h, l;
    logic [3:0]    re;
    logic [DW-1:0] act [4];

    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 4'h0, '0, '0, '0, '0);

    //            rst we1 wa1 wd1            we2 wa2 wd2           wh hi            lo            re       ra1..ra4      e1..e4                                                  ehi           elo
    vecs[0]  = mk(1, 1, 5, 32'h5555_5555, 0, 0, 32'h0,         0, 32'h0,        32'h0,        4'hF, 5, 5, 5, 5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[1]  = mk(1, 1, 5, 32'h5555_5555, 0, 0, 32'h0,         0, 32'h0,        32'h0,        4'hF, 5, 5, 5, 5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,        32'h0,        4'hF, 5, 5, 5, 5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[3]  = mk(0, 1, 3, 32'h1111_1111, 1, 7, 32'h2222_2222, 0, 32'h0,        32'h0,        4'hF, 3, 0, 1, 7, 32'h1111_1111, 32'h0, 32'h0, 32'h2222_2222, 32'h0, 32'h0);
    vecs[4]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,        32'h0,        4'hF, 3, 7, 3, 7, 32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0);
    vecs[5]  = mk(0, 1, 9, 32'hAAAA_0000, 1, 9, 32'hBBBB_0000, 0, 32'h0,        32'h0,        4'hF, 9, 9, 9, 9, 32'hBBBB_0000, 32'hBBBB_0000, 32'hBBBB_0000, 32'hBBBB_0000, 32'h0, 32'h0);
    vecs[6]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,        32'h0,        4'hF, 9, 9, 9, 9, 32'hBBBB_0000, 32'hBBBB_0000, 32'hBBBB_0000, 32'hBBBB_0000, 32'h0, 32'h0);
    vecs[7]  = mk(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 0, 32'h0,        32'h0,        4'hF, 0, 0, 3, 0, 32'h0, 32'h0, 32'h1111_1111, 32'h0, 32'h0, 32'h0);
    vecs[8]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,        32'h0,        4'hF, 0, 0, 9, 0, 32'h0, 32'h0, 32'hBBBB_0000, 32'h0, 32'h0, 32'h0);
    vecs[9]  = mk(0, 1, 4, 32'h1234_5678, 0, 0, 32'h0,         0, 32'h0,        32'h0,        4'hE, 4, 4, 4, 4, 32'h0, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0);
    vecs[10] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,        32'h0,        4'hD, 4, 4, 4, 4, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0);
    vecs[11] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'hDEAD_BEEF, 32'h0000_0042, 4'hF, 3, 7, 9, 4, 32'h1111_1111, 32'h2222_2222, 32'hBBBB_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0042);
    vecs[12] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'hCAFE_F00D, 32'h5555_0000, 4'hF, 3, 7, 9, 4, 32'h1111_1111, 32'h2222_2222, 32'hBBBB_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0042);
    vecs[13] = mk(1, 1, 3, 32'h0000_0999, 1, 7, 32'h0000_0888, 1, 32'h0000_0001, 32'h0000_0002, 4'hF, 3, 7, 9, 4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[14] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,        32'h0,        4'hF, 3, 7, 9, 4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[15] = mk(0, 1, 3, 32'h0000_0077, 0, 0, 32'h0,         0, 32'h0,        32'h0,        4'hF, 3, 3, 7, 0, 32'h0000_0077, 32'h0000_0077, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[16] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,        32'h0,        4'hF, 3, 3, 7, 0, 32'h0000_0077, 32'h0000_0077, 32'h0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].rst, vecs[i].we1, vecs[i].wa1, vecs[i].wd1,
            vecs[i].we2, vecs[i].wa2, vecs[i].wd2,
            vecs[i].whilo, vecs[i].hi, vecs[i].lo, vecs[i].re,
            vecs[i].ra1, vecs[i].ra2, vecs[i].ra3, vecs[i].ra4);
      @(negedge clk);
      check($sformatf("vec%0d rdata1", i), rdata1_o, vecs[i].e1);
      check($sformatf("vec%0d rdata2", i), rdata2_o, vecs[i].e2);
      check($sformatf("vec%0d rdata3", i), rdata3_o, vecs[i].e3);
      check($sformatf("vec%0d rdata4", i), rdata4_o, vecs[i].e4);
      check($sformatf("vec%0d hi", i), hi_o, vecs[i].ehi);
      check($sformatf("vec%0d lo", i), lo_o, vecs[i].elo);
    end

    // State left behind by the table: reset at vec 13, then r3 = 0x77.
    for (int i = 0; i < 2**AW; i++) m_regs[i] = '0;
    m_regs[3] = 32'h0000_0077;
    m_hi = '0;
    m_lo = '0;

    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(0, 39) == 0);
      w1 = $urandom_range(0, 1) == 1;
      w2 = $urandom_range(0, 1) == 1;
      wh = $urandom_range(0, 3) == 0;
      // Mostly low addresses so that collisions and bypass hits are common.
      a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      d1 = $urandom;
      d2 = $urandom;
      h  = $urandom;
      l  = $urandom;
      re = 4'($urandom) | 4'($urandom);
      for (int k = 0; k < 4; k++) ra[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));

      @(posedge clk);
      #1;
      drive(r, w1, a1, d1, w2, a2, d2, wh, h, l, re, ra[0], ra[1], ra[2], ra[3]);

      // What the architectural state becomes once this cycle commits; a
      // reader sees exactly that value (bypass) unless reset or disabled.
      for (int i = 0; i < 2**AW; i++) nxt[i] = m_regs[i];
      if (w1) nxt[a1] = d1;
      if (w2) nxt[a2] = d2;
      nxt[0] = '0;
      nhi = wh ? h : m_hi;
      nlo = wh ? l : m_lo;
      if (r) begin
        for (int i = 0; i < 2**AW; i++) nxt[i] = '0;
        nhi = '0;
        nlo = '0;
      end

      @(negedge clk);
      act[0] = rdata1_o; act[1] = rdata2_o; act[2] = rdata3_o; act[3] = rdata4_o;
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rand%0d rdata%0d (raddr=%0d re=%b)", c, k + 1, ra[k], re[k]),
              act[k], re[k] ? nxt[ra[k]] : '0);
      end
      check($sformatf("rand%0d hi", c), hi_o, nhi);
      check($sformatf("rand%0d lo", c), lo_o, nlo);

      for (int i = 0; i < 2**AW; i++) m_regs[i] = nxt[i];
      m_hi = nhi;
      m_lo = nlo;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_dual
`default_nettype wire
